heapsort_bank_ctrl: RTL and testbench
=====================================

// Module: heapsort_bank_ctrl
// PURPOSE
//  Ping-pong scheduler between the fs-rate sample capture path and the heapsort engine.
//  Owns both banks of the dual-port RAM and fills one bank from data_in while the engine sorts the other.
//  Arbitrates RAM port B between the engine and the sorted-frame drain reader.
//  Streams each sorted frame out on data_out.
// PARAMETERS
//  DATA_W  16  sample width
//  ADDR_W  10  log2 frame length; N = 2**ADDR_W samples per bank
//  OVR_W   8   overrun counter width (only with HS_OVR_CNT_EN)
// PORTS
//  clk         in   1         system clock
//  rst         in   1         asynchronous reset, active-low (asserted at 0)
//  fs          in   1         sample-rate signal, synchronous to clk; each rising edge = one sample
//  en_rec_in   in   1         capture enable
//  data_in     in   DATA_W    input sample
//  ram_a_addr  out  ADDR_W+1  port A address {bank, index}; capture writes only
//  ram_a_we    out  1         port A write enable
//  ram_a_din   out  DATA_W    port A write data
//  ram_b_addr  out  ADDR_W+1  port B address {sort_bank, index}
//  ram_b_we    out  1         port B write enable
//  ram_b_din   out  DATA_W    port B write data
//  ram_b_dout  in   DATA_W    port B read data; 1-cycle read latency
//  srt_start   out  1         1-cycle pulse: sort bank ready
//  srt_done    in   1         1-cycle pulse from engine: sort complete
//  srt_addr    in   ADDR_W    engine address (bank-relative)
//  srt_we      in   1         engine write enable
//  srt_din     in   DATA_W    engine write data
//  srt_dout    out  DATA_W    = ram_b_dout passthrough to engine
//  data_out    out  DATA_W    sorted sample
//  data_valid  out  1         data_out qualifier
//  frame_last  out  1         high with the last word of a frame
//  fill_bank   out  1         bank being filled
//  overrun     out  1         sticky; sample dropped because both banks busy
// BEHAVIOUR
//  Reset: all outputs 0; fill_bank=0, sort_bank=1, wr_ptr=rd_ptr=0, fill_full=0, FSM=S_IDLE, fs_d=0.
//  Capture: stb = fs & ~fs_d & en_rec_in. On stb with !fill_full, write data_in to {fill_bank,wr_ptr} the same cycle, then wr_ptr++.
//   en_rec_in=0 pauses capture; wr_ptr holds.
//   Writing index N-1 sets fill_full; wr_ptr wraps to 0.
//   stb while fill_full: no write; overrun<=1.
//  Swap: occurs in the cycle where fill_full && FSM==S_IDLE.
//   Actions: sort_bank<=fill_bank; fill_bank<=~fill_bank; fill_full<=0; FSM->S_SORT; srt_start=1 next cycle only.
//   If drain ends in the same cycle fill_full rises, the swap waits one cycle (registered state check).
//  FSM sort side: S_IDLE -> S_SORT -> S_DRAIN -> S_IDLE.
//   S_IDLE: ram_b_we=0, ram_b_addr=0.
//   S_SORT: ram_b_addr={sort_bank,srt_addr}, ram_b_we=srt_we, ram_b_din=srt_din (combinational mux).
//     srt_done -> S_DRAIN, rd_ptr=0. srt_done outside S_SORT is ignored.
//   S_DRAIN: ram_b_addr={sort_bank,rd_ptr}, we=0, rd_ptr++ each clk.
//     data_valid/data_out follow the address by 1 clk: N consecutive valid cycles, frame_last on the Nth.
//     After index N-1 is issued -> S_IDLE; the pipeline flushes its last word.
//  Port A is never touched by the engine; ram_a_we=0 when not capturing.
//  overrun clears only on reset.
//  Reset mid-operation: immediate return to reset values; in-flight frame discarded; engine shares rst.
// CONFIGURATION
//  HS_OVR_CNT_EN defined: adds output ovr_cnt [OVR_W-1:0]; +1 per dropped sample; saturates at all-ones; reset to 0.
//  HS_OVR_CNT_EN undefined: no ovr_cnt port; only sticky overrun.
// STRUCTURE
//  heapsort_pkg: DATA_W/ADDR_W defaults; state localparams S_IDLE=2'd0, S_SORT=2'd1, S_DRAIN=2'd2.
//  Sub-module heapsort_capture: fs edge detect, wr_ptr, fill_full, overrun/ovr_cnt.
//  Top level: bank swap, sort FSM, port-B mux, drain pipeline.
// TESTING (ADDR_W=3 unless noted; stub engine)
//  1 Ramp: 8 fs edges carrying 7..0 -> writes to bank 0 addr 0..7; fill_bank=1; srt_start 1 pulse.
//    Stub does srt_done after 20 clk -> data_out 7,6,..,0 on 8 consecutive valid cycles; frame_last on value 0.
//  2 Overrun: stub never sends srt_done; 8 more edges fill bank 1, then 9 more edges -> no ram_a_we; overrun=1; ovr_cnt=9 (macro on).
//  3 Pause: en_rec_in=0 for 3 fs edges after 4 samples -> no writes; the next sample lands at index 4.
//  4 Arbitration: in S_SORT drive srt_addr=5, srt_we=1, srt_din=16'hABCD -> ram_b_addr=4'b1101 (sort_bank=1), ram_b_we=1; in S_IDLE ram_b_we=0.
//  5 Reset mid-drain: rst=0 at 3rd valid word -> data_valid=0, fill_bank=0, srt_start=0 asynchronously; the next frame starts at bank 0 index 0.
//  6 ADDR_W=10, real heapsort engine, rand_lvl_10.hex input -> 1024 monotonically ordered words; overrun=0.

Source files
------------

// File: rtl/heapsort_pkg.sv
// Shared defaults and sort-side state encoding for the heapsort bank controller.
package heapsort_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 10;
    localparam int OVR_W_DEF  = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SORT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/heapsort_capture.sv
// Capture side of the ping-pong scheduler: fs edge detect, fill pointer, full flag, overrun tracking.
// With HS_OVR_CNT_EN defined a saturating dropped-sample counter is also provided.
module heapsort_capture
    import heapsort_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
`ifdef HS_OVR_CNT_EN
    ,
    parameter int OVR_W  = OVR_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fs,
    input  logic              en_rec_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fill_bank,
    input  logic              swap,
    output logic [ADDR_W:0]   ram_a_addr,
    output logic              ram_a_we,
    output logic [DATA_W-1:0] ram_a_din,
    output logic              fill_full,
    output logic              overrun
`ifdef HS_OVR_CNT_EN
    ,
    output logic [OVR_W-1:0]  ovr_cnt
`endif
);

    localparam logic [ADDR_W-1:0] IDX_LAST = '1;

    logic              fs_d;
    logic [ADDR_W-1:0] wr_ptr;
    logic              stb;
    logic              wr;
    logic              drop;

`ifdef HS_OVR_CNT_EN
    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
`endif

    assign stb  = fs & ~fs_d & en_rec_in;
    assign wr   = stb & ~fill_full;
    assign drop = stb & fill_full;

    // Write goes out combinationally in the strobe cycle; data is zeroed when idle
    assign ram_a_we   = wr;
    assign ram_a_addr = {fill_bank, wr_ptr};
    assign ram_a_din  = wr ? data_in : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fs_d      <= 1'b0;
            wr_ptr    <= '0;
            fill_full <= 1'b0;
            overrun   <= 1'b0;
`ifdef HS_OVR_CNT_EN
            ovr_cnt   <= '0;
`endif
        end else begin
            fs_d <= fs;
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (swap) begin
                fill_full <= 1'b0;
            end else if (wr && (wr_ptr == IDX_LAST)) begin
                fill_full <= 1'b1;
            end
            if (drop) begin
                overrun <= 1'b1;
`ifdef HS_OVR_CNT_EN
                ovr_cnt <= sat_inc(ovr_cnt);
`endif
            end
        end
    end

endmodule

// File: rtl/heapsort_bank_ctrl.sv
// Ping-pong bank scheduler between fs-rate capture and the heapsort engine, with port-B arbitration
// and sorted-frame drain. HS_OVR_CNT_EN adds the ovr_cnt dropped-sample counter output.
module heapsort_bank_ctrl
    import heapsort_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
`ifdef HS_OVR_CNT_EN
    ,
    parameter int OVR_W  = OVR_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fs,
    input  logic              en_rec_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W:0]   ram_a_addr,
    output logic              ram_a_we,
    output logic [DATA_W-1:0] ram_a_din,
    output logic [ADDR_W:0]   ram_b_addr,
    output logic              ram_b_we,
    output logic [DATA_W-1:0] ram_b_din,
    input  logic [DATA_W-1:0] ram_b_dout,
    output logic              srt_start,
    input  logic              srt_done,
    input  logic [ADDR_W-1:0] srt_addr,
    input  logic              srt_we,
    input  logic [DATA_W-1:0] srt_din,
    output logic [DATA_W-1:0] srt_dout,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_last,
    output logic              fill_bank,
    output logic              overrun
`ifdef HS_OVR_CNT_EN
    ,
    output logic [OVR_W-1:0]  ovr_cnt
`endif
);

    localparam logic [ADDR_W-1:0] IDX_LAST = '1;

    state_t            state;
    logic              sort_bank;
    logic              fill_full;
    logic              swap;
    logic [ADDR_W-1:0] rd_ptr;
    logic              vld_p1;
    logic              last_p1;

    // Registered state and fill_full: a drain ending as the bank fills defers the swap a cycle
    assign swap = fill_full && (state == S_IDLE);

    heapsort_capture #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
`ifdef HS_OVR_CNT_EN
        ,
        .OVR_W  (OVR_W)
`endif
    ) u_capture (
        .clk        (clk),
        .rst        (rst),
        .fs         (fs),
        .en_rec_in  (en_rec_in),
        .data_in    (data_in),
        .fill_bank  (fill_bank),
        .swap       (swap),
        .ram_a_addr (ram_a_addr),
        .ram_a_we   (ram_a_we),
        .ram_a_din  (ram_a_din),
        .fill_full  (fill_full),
        .overrun    (overrun)
`ifdef HS_OVR_CNT_EN
        ,
        .ovr_cnt    (ovr_cnt)
`endif
    );

    // Stage p0: port B address issue (engine in S_SORT, drain reader in S_DRAIN)
    always_comb begin
        ram_b_addr = '0;
        ram_b_we   = 1'b0;
        ram_b_din  = '0;
        case (state)
            S_SORT: begin
                ram_b_addr = {sort_bank, srt_addr};
                ram_b_we   = srt_we;
                ram_b_din  = srt_din;
            end
            S_DRAIN: begin
                ram_b_addr = {sort_bank, rd_ptr};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            fill_bank <= 1'b0;
            sort_bank <= 1'b1;
            rd_ptr    <= '0;
            srt_start <= 1'b0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
        end else begin
            srt_start <= swap;
            vld_p1    <= (state == S_DRAIN);
            last_p1   <= (state == S_DRAIN) && (rd_ptr == IDX_LAST);
            case (state)
                S_IDLE: begin
                    if (swap) begin
                        sort_bank <= fill_bank;
                        fill_bank <= ~fill_bank;
                        state     <= S_SORT;
                    end
                end
                S_SORT: begin
                    if (srt_done) begin
                        rd_ptr <= '0;
                        state  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    rd_ptr <= rd_ptr + 1'b1;
                    if (rd_ptr == IDX_LAST) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stage p1: RAM read data returns, qualified by the delayed valid
    assign data_valid = vld_p1;
    assign frame_last = last_p1;
    assign data_out   = vld_p1 ? ram_b_dout : '0;
    assign srt_dout   = ram_b_dout;

endmodule

// File: tb/tb_heapsort_bank_ctrl.sv
// Directed/randomized bench for heapsort_bank_ctrl with ADDR_W=3, a RAM model and a stub engine.
module tb_heapsort_bank_ctrl;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fs = 1'b0;
    logic          en_rec_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [AW:0]   ram_a_addr;
    logic          ram_a_we;
    logic [DW-1:0] ram_a_din;
    logic [AW:0]   ram_b_addr;
    logic          ram_b_we;
    logic [DW-1:0] ram_b_din;
    logic [DW-1:0] ram_b_dout;
    logic          srt_start;
    logic          srt_done = 1'b0;
    logic [AW-1:0] srt_addr = '0;
    logic          srt_we = 1'b0;
    logic [DW-1:0] srt_din = '0;
    logic [DW-1:0] srt_dout;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          frame_last;
    logic          fill_bank;
    logic          overrun;
`ifdef HS_OVR_CNT_EN
    logic [7:0]    ovr_cnt;
`endif

    heapsort_bank_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .fs         (fs),
        .en_rec_in  (en_rec_in),
        .data_in    (data_in),
        .ram_a_addr (ram_a_addr),
        .ram_a_we   (ram_a_we),
        .ram_a_din  (ram_a_din),
        .ram_b_addr (ram_b_addr),
        .ram_b_we   (ram_b_we),
        .ram_b_din  (ram_b_din),
        .ram_b_dout (ram_b_dout),
        .srt_start  (srt_start),
        .srt_done   (srt_done),
        .srt_addr   (srt_addr),
        .srt_we     (srt_we),
        .srt_din    (srt_din),
        .srt_dout   (srt_dout),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_last (frame_last),
        .fill_bank  (fill_bank),
        .overrun    (overrun)
`ifdef HS_OVR_CNT_EN
        ,
        .ovr_cnt    (ovr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Dual-port RAM model, 1-cycle read latency on port B
    logic [DW-1:0] mem [0:2*N-1];
    int            a_wr_cnt = 0;
    logic [AW:0]   a_last_addr = '0;
    int            cyc = 0;
    int            start_cnt = 0;
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    int            got_c[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_a_we) begin
            mem[ram_a_addr] <= ram_a_din;
            a_wr_cnt        <= a_wr_cnt + 1;
            a_last_addr     <= ram_a_addr;
        end
        if (ram_b_we) mem[ram_b_addr] <= ram_b_din;
        ram_b_dout <= mem[ram_b_addr];
    end

    always @(negedge clk) begin
        if (data_valid) begin
            got_d.push_back(data_out);
            got_l.push_back(frame_last);
            got_c.push_back(cyc);
        end
        if (srt_start) start_cnt <= start_cnt + 1;
    end

    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] sav_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] v, input logic en);
        en_rec_in = en;
        data_in   = v;
        fs        = 1'b1;
        tick(2);
        fs        = 1'b0;
        tick(2);
    endtask

    task automatic capture_random();
        logic [DW-1:0] v;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            v = DW'($urandom);
            exp_q.push_back(v);
            send(v, 1'b1);
        end
    endtask

    task automatic wait_start(input int target, input string tag);
        int n = 0;
        while (start_cnt < target && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(start_cnt >= target), 1);
    endtask

    task automatic noop_engine();
        tick(20);
        srt_done = 1'b1;
        tick();
        srt_done = 1'b0;
    endtask

    // Reads the sort bank, sorts ascending, writes it back through the arbitrated port
    task automatic sort_engine();
        logic [DW-1:0] vals[$];
        for (int i = 0; i <= N; i++) begin
            if (i > 0) vals.push_back(srt_dout);
            if (i < N) srt_addr = AW'(i);
            tick();
        end
        vals.sort();
        for (int i = 0; i < N; i++) begin
            srt_addr = AW'(i);
            srt_din  = vals[i];
            srt_we   = 1'b1;
            tick();
        end
        srt_we = 1'b0;
        exp_q  = vals;
        tick(2);
        srt_done = 1'b1;
        tick();
        srt_done = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        int n = 0;
        while (got_d.size() < N && n < 300) begin
            tick();
            n++;
        end
        tick(3);
        chk($sformatf("%s_cnt", tag), 32'(got_d.size()), N);
        for (int i = 0; i < N && i < got_d.size(); i++) begin
            chk($sformatf("%s_d%0d", tag, i), 32'(got_d[i]), 32'(exp_q[i]));
            chk($sformatf("%s_last%0d", tag, i), 32'(got_l[i]), 32'(i == N - 1));
            chk($sformatf("%s_cyc%0d", tag, i), 32'(got_c[i] - got_c[0]), 32'(i));
        end
        got_d.delete();
        got_l.delete();
        got_c.delete();
    endtask

    initial begin
        int s0;
        int w0;
        int n;
        logic [DW-1:0] v;

        // Reset state
        tick(3);
        chk("rst_fill_bank", 32'(fill_bank), 0);
        chk("rst_data_valid", 32'(data_valid), 0);
        chk("rst_srt_start", 32'(srt_start), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_ram_a_we", 32'(ram_a_we), 0);
        chk("rst_ram_b_we", 32'(ram_b_we), 0);
        rst = 1'b1;
        tick(2);

        // Ramp 7..0 into bank 0, no-op engine, frame drains in stored order
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(DW'(N - 1 - i));
            send(DW'(N - 1 - i), 1'b1);
        end
        for (int i = 0; i < N; i++) chk($sformatf("ramp_mem%0d", i), 32'(mem[i]), 32'(N - 1 - i));
        wait_start(1, "ramp_start");
        chk("ramp_fill_bank", 32'(fill_bank), 1);
        tick(5);
        chk("ramp_start_once", 32'(start_cnt), 1);
        noop_engine();
        drain_check("ramp");

        // Random frame into bank 1; engine write through port B lands at {1,5}
        capture_random();
        wait_start(2, "arb_start");
        chk("arb_fill_bank", 32'(fill_bank), 0);
        srt_addr = 3'd5;
        srt_din  = 16'hABCD;
        srt_we   = 1'b1;
        #1;
        chk("arb_b_addr", 32'(ram_b_addr), 32'(4'b1101));
        chk("arb_b_we", 32'(ram_b_we), 1);
        chk("arb_b_din", 32'(ram_b_din), 32'h0000ABCD);
        tick();
        srt_we = 1'b0;
        exp_q[5] = 16'hABCD;
        noop_engine();
        drain_check("arb");
        srt_we   = 1'b1;
        srt_addr = 3'd3;
        #1;
        chk("idle_b_we", 32'(ram_b_we), 0);
        chk("idle_b_addr", 32'(ram_b_addr), 0);
        srt_we = 1'b0;
        tick();

        // Random frame into bank 0, sorted by the stub engine
        capture_random();
        wait_start(3, "sort_start");
        sort_engine();
        drain_check("sort");

        // Pause: 4 samples, 3 disabled edges, 4 more; fifth write lands at {1,4}
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            v = DW'($urandom);
            exp_q.push_back(v);
            send(v, 1'b1);
        end
        w0 = a_wr_cnt;
        for (int i = 0; i < 3; i++) send(DW'($urandom), 1'b0);
        chk("pause_no_write", 32'(a_wr_cnt - w0), 0);
        for (int i = 0; i < 4; i++) begin
            v = DW'($urandom);
            exp_q.push_back(v);
            send(v, 1'b1);
            if (i == 0) chk("pause_resume_addr", 32'(a_last_addr), 32'(4'b1100));
        end
        wait_start(4, "pause_start");
        noop_engine();
        drain_check("pause");

        // Overrun: engine never finishes, second bank fills, 9 further samples dropped
        capture_random();
        sav_q = exp_q;
        wait_start(5, "ovr_start");
        chk("ovr_before", 32'(overrun), 0);
        for (int i = 0; i < N; i++) send(DW'($urandom), 1'b1);
        w0 = a_wr_cnt;
        s0 = start_cnt;
        for (int i = 0; i < 9; i++) send(DW'($urandom), 1'b1);
        chk("ovr_no_write", 32'(a_wr_cnt - w0), 0);
        chk("ovr_sticky", 32'(overrun), 1);
        chk("ovr_no_swap", 32'(start_cnt - s0), 0);
        chk("ovr_fill_bank", 32'(fill_bank), 1);
`ifdef HS_OVR_CNT_EN
        chk("ovr_cnt", 32'(ovr_cnt), 9);
`endif

        // Reset during the drain of the stalled frame
        exp_q = sav_q;
        srt_done = 1'b1;
        tick();
        srt_done = 1'b0;
        n = 0;
        while (got_d.size() < 2 && n < 300) begin
            tick();
            n++;
        end
        chk("mid_w0", 32'(got_d.size() > 0 ? got_d[0] : 'x), 32'(exp_q[0]));
        chk("mid_third_valid", 32'(data_valid), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(data_valid), 0);
        chk("mid_rst_fill_bank", 32'(fill_bank), 0);
        chk("mid_rst_srt_start", 32'(srt_start), 0);
        chk("mid_rst_overrun", 32'(overrun), 0);
        chk("mid_rst_last", 32'(frame_last), 0);
`ifdef HS_OVR_CNT_EN
        chk("mid_rst_ovr_cnt", 32'(ovr_cnt), 0);
`endif
        tick(2);
        rst = 1'b1;
        tick(2);
        got_d.delete();
        got_l.delete();
        got_c.delete();
        s0 = start_cnt;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            v = DW'($urandom);
            exp_q.push_back(v);
            send(v, 1'b1);
            if (i == 0) chk("post_rst_addr", 32'(a_last_addr), 0);
        end
        wait_start(s0 + 1, "post_rst_start");
        noop_engine();
        drain_check("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
